// File: rtl/dac_sweep_sequencer.sv
// Triangular (cyclic-voltammetry) sweep: walks a DAC code between two vertices and back to the start code.
// Each code is handed to the DAC via req/ack; one ADC strobe fires period+1 clocks after every ack.
module dac_sweep_sequencer #(
    parameter int DAC_W = 8,
    parameter int PER_W = 16,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DAC_W-1:0] v_start,
    input  logic [DAC_W-1:0] v_low,
    input  logic [DAC_W-1:0] v_high,
    input  logic [DAC_W-1:0] step,
    input  logic [PER_W-1:0] period,
    input  logic [CYC_W-1:0] n_cycles,
    input  logic             dir_up,
    output logic [DAC_W-1:0] dac_code,
    output logic             dac_req,
    input  logic             dac_ack,
    output logic             adc_trig,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             cfg_err,
    output logic [CYC_W-1:0] cycle_cnt
);
    localparam int TRN_W = CYC_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SAMPLE,
        S_STEP
    } state_t;

    state_t state_q, state_d;

    logic [DAC_W-1:0] v_start_q, v_low_q, v_high_q, step_q;
    logic [PER_W-1:0] period_q;
    logic [CYC_W-1:0] ncyc_q;

    logic [DAC_W-1:0] code_q, code_d;
    logic             dir_q, dir_d;
    logic [TRN_W-1:0] turns_q, turns_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             fin_q, fin_d;
    logic             done_q, aborted_q, cfg_err_q;

    logic cfg_ok, start_ok, kill;

    assign cfg_ok   = (v_low <= v_start) && (v_start <= v_high) && (step != '0)
                      && (period != '0) && (n_cycles != '0);
    assign start_ok = (state_q == S_IDLE) && start && cfg_ok;
    assign kill     = (state_q != S_IDLE) && abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ok) state_d = S_LOAD;
            S_LOAD:   if (dac_ack) state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == '0) state_d = S_SAMPLE;
            S_SAMPLE: state_d = fin_q ? S_IDLE : S_STEP;
            S_STEP:   state_d = S_LOAD;
            default:  state_d = S_IDLE;
        endcase
        // abort outranks ack and settle expiry, so a pending strobe never fires
        if (kill) state_d = S_IDLE;
    end

    // Step arithmetic is one bit wider so code+step can never wrap past the vertex.
    logic             fin_leg, hit;
    logic [DAC_W-1:0] tgt;
    logic [DAC_W:0]   sum_x;

    always_comb begin
        fin_leg = (turns_q == {ncyc_q, 1'b0});
        tgt     = fin_leg ? v_start_q : (dir_q ? v_high_q : v_low_q);
        sum_x   = {1'b0, code_q} + {1'b0, step_q};
        if (dir_q) hit = (sum_x >= {1'b0, tgt});
        else       hit = ({1'b0, code_q} <= ({1'b0, tgt} + {1'b0, step_q}));
    end

    always_comb begin
        code_d  = code_q;
        dir_d   = dir_q;
        turns_d = turns_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    code_d  = v_start;
                    dir_d   = dir_up;
                    turns_d = '0;
                    cyc_d   = '0;
                    fin_d   = 1'b0;
                end
            end
            S_LOAD:   if (dac_ack) cnt_d = period_q - PER_W'(1);
            S_SETTLE: if (cnt_q != '0) cnt_d = cnt_q - PER_W'(1);
            S_STEP: begin
                if (!hit) begin
                    code_d = dir_q ? sum_x[DAC_W-1:0] : (code_q - step_q);
                end else begin
                    code_d = tgt;
                    if (fin_leg) begin
                        fin_d = 1'b1;
                    end else begin
                        dir_d   = ~dir_q;
                        turns_d = turns_q + TRN_W'(1);
                        // every second vertex closes one triangle
                        if (turns_q[0]) cyc_d = cyc_q + CYC_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_start_q <= '0;
            v_low_q   <= '0;
            v_high_q  <= '0;
            step_q    <= '0;
            period_q  <= '0;
            ncyc_q    <= '0;
            code_q    <= '0;
            dir_q     <= 1'b0;
            turns_q   <= '0;
            cyc_q     <= '0;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            if (start_ok) begin
                v_start_q <= v_start;
                v_low_q   <= v_low;
                v_high_q  <= v_high;
                step_q    <= step;
                period_q  <= period;
                ncyc_q    <= n_cycles;
            end
            code_q    <= code_d;
            dir_q     <= dir_d;
            turns_q   <= turns_d;
            cyc_q     <= cyc_d;
            cnt_q     <= cnt_d;
            fin_q     <= fin_d;
            done_q    <= (state_q == S_SAMPLE) && fin_q && !abort;
            aborted_q <= kill;
            cfg_err_q <= (state_q == S_IDLE) && start && !cfg_ok;
        end
    end

    always_comb begin
        dac_req   = (state_q == S_LOAD);
        adc_trig  = (state_q == S_SAMPLE);
        busy      = (state_q != S_IDLE);
        dac_code  = code_q;
        done      = done_q;
        aborted   = aborted_q;
        cfg_err   = cfg_err_q;
        cycle_cnt = cyc_q;
    end
endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// Bench for dac_sweep_sequencer: directed scenarios plus random sweeps against a leg-by-leg code model.
module tb_dac_sweep_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, dir_up = 1'b1, dac_ack = 1'b0;
    logic [7:0] v_start = '0, v_low = '0, v_high = '0, step = '0;
    logic [15:0] period = '0;
    logic [7:0] n_cycles = '0;
    logic [7:0] dac_code, cycle_cnt;
    logic       dac_req, adc_trig, busy, done, aborted, cfg_err;

    int n_checks = 0;
    int n_fail = 0;
    int exp_q[$];

    dac_sweep_sequencer #(.DAC_W(8), .PER_W(16), .CYC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .v_start(v_start), .v_low(v_low), .v_high(v_high), .step(step),
        .period(period), .n_cycles(n_cycles), .dir_up(dir_up),
        .dac_code(dac_code), .dac_req(dac_req), .dac_ack(dac_ack),
        .adc_trig(adc_trig), .busy(busy), .done(done), .aborted(aborted),
        .cfg_err(cfg_err), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sweep = 2*nc vertex legs then one leg back to v_start; each leg moves by step, clamping on reach/pass.
    function automatic void build_model(int vs, int vl, int vh, int st, int nc, bit du);
        int c, tgt;
        bit d, arrived;
        exp_q.delete();
        c = vs;
        d = du;
        exp_q.push_back(c);
        for (int leg = 0; leg <= 2 * nc; leg++) begin
            tgt = (leg == 2 * nc) ? vs : (d ? vh : vl);
            arrived = 1'b0;
            while (!arrived) begin
                if (d) c = (c + st >= tgt) ? tgt : c + st;
                else   c = (c - st <= tgt) ? tgt : c - st;
                arrived = (c == tgt);
                exp_q.push_back(c);
            end
            d = !d;
        end
    endfunction

    task automatic apply_cfg(int vs, int vl, int vh, int st, int per, int nc, bit du);
        v_start = 8'(vs); v_low = 8'(vl); v_high = 8'(vh); step = 8'(st);
        period = 16'(per); n_cycles = 8'(nc); dir_up = du;
    endtask

    task automatic run_sweep(string nm, int vs, int vl, int vh, int st, int per, int nc, bit du,
                             int ack_dly, int abort_k);
        int n;
        bit seen;
        build_model(vs, vl, vh, st, nc, du);
        apply_cfg(vs, vl, vh, st, per, nc, du);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_at_load: got %0b want 1", nm, busy); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (dac_req !== 1'b1 || dac_code !== 8'(exp_q[k])) begin
                n_fail++; $display("FAIL %s code[%0d]: got req=%0b code=%0d want req=1 code=%0d", nm, k, dac_req, dac_code, exp_q[k]);
            end
            for (int i = 0; i < ack_dly; i++) begin
                tick();
                n_checks++;
                if (dac_req !== 1'b1 || dac_code !== 8'(exp_q[k]) || adc_trig !== 1'b0) begin
                    n_fail++; $display("FAIL %s hold[%0d] cyc %0d: got req=%0b code=%0d trig=%0b want 1/%0d/0", nm, k, i, dac_req, dac_code, adc_trig, exp_q[k]);
                end
            end
            dac_ack = 1'b1;
            abort = (k == abort_k);
            tick();
            dac_ack = 1'b0;
            if (abort) begin
                abort = 1'b0;
                n_checks++;
                if (aborted !== 1'b1 || busy !== 1'b0 || dac_req !== 1'b0) begin
                    n_fail++; $display("FAIL %s abort_resp: got aborted=%0b busy=%0b req=%0b want 1/0/0", nm, aborted, busy, dac_req);
                end
                seen = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    tick();
                    seen |= adc_trig | done | aborted | busy;
                end
                n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL %s after_abort_quiet: got activity=%0b want 0", nm, seen); end
                return;
            end
            n_checks++; if (dac_req !== 1'b0) begin n_fail++; $display("FAIL %s req_drop[%0d]: got %0b want 0", nm, k, dac_req); end
            n = 1;
            while (adc_trig !== 1'b1 && n < per + 10) begin
                tick();
                n++;
            end
            n_checks++; if (n != per + 1) begin n_fail++; $display("FAIL %s trig_latency[%0d]: got %0d want %0d", nm, k, n, per + 1); end
            tick();
            if (k == exp_q.size() - 1) begin
                n_checks++;
                if (done !== 1'b1 || busy !== 1'b0 || cycle_cnt !== 8'(nc)) begin
                    n_fail++; $display("FAIL %s completion: got done=%0b busy=%0b cyc=%0d want 1/0/%0d", nm, done, busy, cycle_cnt, nc);
                end
                tick();
                n_checks++; if (done !== 1'b0 || adc_trig !== 1'b0) begin n_fail++; $display("FAIL %s done_single: got done=%0b trig=%0b want 0/0", nm, done, adc_trig); end
            end else begin
                n_checks++;
                if (done !== 1'b0 || dac_req !== 1'b0 || adc_trig !== 1'b0) begin
                    n_fail++; $display("FAIL %s step_cycle[%0d]: got done=%0b req=%0b trig=%0b want 0/0/0", nm, k, done, dac_req, adc_trig);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({dac_req, adc_trig, busy, done, aborted, cfg_err} !== 6'b0 || dac_code !== 8'd0 || cycle_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_outputs: got req=%0b trig=%0b busy=%0b done=%0b ab=%0b err=%0b code=%0d cyc=%0d want all 0",
                               dac_req, adc_trig, busy, done, aborted, cfg_err, dac_code, cycle_cnt);
        end
    endtask

    task automatic test_abort_idle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        n_checks++; if (aborted !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got aborted=%0b busy=%0b want 0/0", aborted, busy); end
    endtask

    task automatic test_cfg_err(string nm, int vs, int vl, int vh, int st, int per, int nc);
        apply_cfg(vs, vl, vh, st, per, nc, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL %s cfg_err_pulse: got err=%0b busy=%0b want 1/0", nm, cfg_err, busy); end
        tick();
        n_checks++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s cfg_err_clear: got err=%0b busy=%0b want 0/0", nm, cfg_err, busy); end
    endtask

    task automatic test_reset_mid_sweep();
        bit seen;
        apply_cfg(20, 10, 30, 5, 3, 1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        dac_ack = 1'b1;
        tick();
        dac_ack = 1'b0;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({dac_req, adc_trig, busy, done, aborted, cfg_err} !== 6'b0 || dac_code !== 8'd0 || cycle_cnt !== 8'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got req=%0b trig=%0b busy=%0b done=%0b ab=%0b code=%0d want all 0",
                               dac_req, adc_trig, busy, done, aborted, dac_code);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= done | aborted | busy | adc_trig;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_quiet: got activity=%0b want 0", seen); end
    endtask

    task automatic test_random();
        int vl, vh, vs, rng, st, per, nc, ad;
        bit du;
        for (int r = 0; r < 8; r++) begin
            vl  = $urandom_range(100, 0);
            rng = $urandom_range(150, 0);
            vh  = vl + rng;
            vs  = $urandom_range(vh, vl);
            st  = $urandom_range(60, rng / 10 + 1);
            per = $urandom_range(4, 1);
            nc  = $urandom_range(3, 1);
            du  = 1'($urandom_range(1, 0));
            ad  = $urandom_range(3, 0);
            run_sweep($sformatf("rand%0d", r), vs, vl, vh, st, per, nc, du, ad, -1);
        end
    endtask

    initial begin
        test_reset();
        test_abort_idle();
        run_sweep("basic", 20, 10, 30, 5, 3, 1, 1'b1, 2, -1);
        run_sweep("clamp", 20, 10, 29, 5, 3, 1, 1'b1, 2, -1);
        run_sweep("handshake_hold", 20, 10, 30, 5, 3, 1, 1'b1, 10, -1);
        run_sweep("abort", 20, 10, 30, 5, 3, 1, 1'b1, 2, 2);
        run_sweep("after_abort", 20, 10, 30, 5, 3, 1, 1'b1, 0, -1);
        test_cfg_err("step0", 20, 10, 30, 0, 3, 1);
        test_cfg_err("vstart_hi", 40, 10, 30, 5, 3, 1);
        test_cfg_err("ncyc0", 20, 10, 30, 5, 3, 0);
        run_sweep("degenerate", 30, 10, 30, 5, 1, 1, 1'b1, 1, -1);
        run_sweep("no_wrap", 240, 200, 250, 30, 2, 2, 1'b1, 0, -1);
        run_sweep("down_first", 20, 3, 40, 7, 2, 2, 1'b0, 1, -1);
        test_reset_mid_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dac_sweep_sequencer.md
Name: dac_sweep_sequencer

Overview:
- Generates the triangular (cyclic-voltammetry) electrode-potential sweep.
- Steps an 8-bit DAC code between programmable vertices and hands each code to the DAC serial interface through a req/ack handshake.
- Fires one ADC sample strobe per step after a settle interval.
- Sits between the host control wires/triggers and the DAC/ADC controllers, replacing host-paced pipe writes for sweeps.

Parameters:
- DAC_W, 8, DAC code width.
- PER_W, 16, width of the step-period counter.
- CYC_W, 8, width of the cycle counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; latches config and begins a sweep.
- abort  in  1  one-cycle pulse; stops the sweep.
- v_start  in  DAC_W  initial and final code.
- v_low  in  DAC_W  lower vertex.
- v_high  in  DAC_W  upper vertex.
- step  in  DAC_W  code increment per step.
- period  in  PER_W  clocks from DAC ack to ADC strobe.
- n_cycles  in  CYC_W  number of full triangles.
- dir_up  in  1  initial direction (1 = increasing).
- dac_code  out  DAC_W  code presented to the DAC controller.
- dac_req  out  1  code valid; held until ack.
- dac_ack  in  1  DAC controller accepted code.
- adc_trig  out  1  one-cycle sample strobe.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- cycle_cnt  out  CYC_W  completed triangles.

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. Reset mid-sweep returns to IDLE with no done or aborted pulse.
- IDLE:
  - start with valid config: latch all inputs, set code=v_start, dir=dir_up, turns=0, cycle_cnt=0; go to LOAD next cycle with busy=1.
  - Valid config: v_low<=v_start<=v_high, step>=1, period>=1, n_cycles>=1.
  - Invalid config: cfg_err pulses 1 cycle; stay IDLE.
  - start while busy is ignored.
- LOAD:
  - dac_req=1 and dac_code=code, both stable until dac_ack is sampled high.
  - On ack: dac_req drops the next cycle, counter=period-1, go to SETTLE.
  - Ack in the same cycle req first rises is legal and accepted.
- SETTLE: decrement counter; at 0, go to SAMPLE.
- SAMPLE:
  - adc_trig=1 for exactly one cycle.
  - If the final flag is set, go to IDLE: done pulses 1 cycle, busy drops that same cycle.
  - Otherwise go to STEP.
- STEP (one cycle): compute the next code in DAC_W+1 bits, with no wrap.
  - Up leg: nxt=code+step. If nxt>=v_high, set code=v_high, dir=0, turns+1.
  - Down leg: if code<=v_low+step, set code=v_low, dir=1, turns+1. Otherwise code-=step.
  - cycle_cnt increments every second turn.
  - Final leg (turns==2*n_cycles): the clamp target is v_start instead of a vertex. Reaching or passing v_start sets code=v_start and sets the final flag; no further turns occur.
  - Then go to LOAD.
- Per-step latency: ack to adc_trig = period+1 clocks; adc_trig to the next dac_req = 2 clocks.
- abort:
  - Any non-IDLE state goes to IDLE next cycle: aborted pulses, busy=0, dac_req=0.
  - An adc_trig not yet issued is suppressed.
  - abort has priority over a simultaneous dac_ack or a settle expiry.
  - abort in IDLE is ignored. abort and start in the same IDLE cycle: start wins.
- Degenerate case: if v_start equals the first vertex, the first STEP turns immediately; the code stays at the vertex for that step, which produces two samples at the vertex.

Test Plan:
- Basic sweep: v_low=10, v_start=20, v_high=30, step=5, period=3, n_cycles=1, dir_up=1, ack after 2 clocks.
  - Code sequence: 20,25,30,25,20,15,10,15,20.
  - 9 adc_trig pulses, each 4 clocks after its ack.
  - cycle_cnt=1, done pulses once.
- Clamp: v_high=29 in the basic config. Sequence 20,25,29,24,…,10,15,20; no code ever exceeds 29.
- Handshake hold: delay ack by 10 cycles. dac_code and dac_req stay stable for all 10 cycles; no adc_trig until period+1 after ack.
- Abort: pulse abort together with dac_ack during step 3.
  - aborted pulses, no further adc_trig, busy=0, done never asserts.
  - A subsequent start runs normally.
- Config errors, each → cfg_err pulse, busy stays 0:
  - step=0
  - v_start=40 with v_high=30
  - n_cycles=0
- Reset mid-sweep: drive rst_n=0 during SETTLE. All outputs are 0 the next cycle, and no done or aborted pulse is issued.
